imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32 immediate decoder behind a two-entry valid/ready
// pipeline (output register plus one skid entry), one-cycle latency.
// Also counts delivered illegal-opcode results, saturating at all-ones.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drops both pipeline entries at the next edge
//   in_valid/in_ready   input handshake; in_ready = skid entry empty
//   in_instr            raw 32-bit instruction word
//   out_valid/out_ready output handshake
//   out_imm             sign-extended immediate, XLEN bits
//   out_fmt             0=I 1=S 2=B 3=U 4=J 7=none
//   out_illegal         opcode not in the decode table
//   illegal_cnt         saturating count of illegal results delivered
`timescale 1ns/1ps
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_S    = 3'd1;
   localparam logic [2:0] FMT_B    = 3'd2;
   localparam logic [2:0] FMT_U    = 3'd3;
   localparam logic [2:0] FMT_J    = 3'd4;
   localparam logic [2:0] FMT_NONE = 3'd7;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Combinational decode of the incoming word
   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_ill;

   always_comb begin
      dec_imm32 = 32'h0;
      dec_fmt   = FMT_NONE;
      dec_ill   = 1'b1;
      case (in_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_fmt   = FMT_I;
            dec_ill   = 1'b0;
         end
         7'b0011011: begin
            // OP-IMM-32 exists only on RV64
            if (XLEN == 64) begin
               dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
               dec_fmt   = FMT_I;
               dec_ill   = 1'b0;
            end
         end
         7'b0100011: begin
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_fmt   = FMT_S;
            dec_ill   = 1'b0;
         end
         7'b1100011: begin
            dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            dec_fmt   = FMT_B;
            dec_ill   = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            dec_imm32 = {in_instr[31:12], 12'h000};
            dec_fmt   = FMT_U;
            dec_ill   = 1'b0;
         end
         7'b1101111: begin
            dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            dec_fmt   = FMT_J;
            dec_ill   = 1'b0;
         end
         7'b0110011: begin
            dec_ill = 1'b0;
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase
   end

   assign dec_imm = XLEN'($signed(dec_imm32));

   // Pipeline state
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic [2:0]       out_fmt_q,   out_fmt_d;
   logic             out_ill_q,   out_ill_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
   logic [2:0]       skid_fmt_q,  skid_fmt_d;
   logic             skid_ill_q,  skid_ill_d;
   logic             in_ready_q,  in_ready_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic in_acc;
   logic out_hs;

   // Next-state: skid drains before new input, flush kills both entries
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_fmt_d    = out_fmt_q;
      out_ill_d    = out_ill_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;
      skid_ill_d   = skid_ill_q;
      cnt_d        = cnt_q;

      in_acc = in_valid & in_ready_q & ~flush;
      out_hs = out_valid_q & out_ready;

      // Counting happens even in a flush cycle: the result was delivered
      if (out_hs && out_ill_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_fmt_d    = skid_fmt_q;
            out_ill_d    = skid_ill_q;
            skid_valid_d = 1'b0;
         end else if (in_acc) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_fmt_d   = dec_fmt;
            out_ill_d   = dec_ill;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_acc) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_fmt_d   = dec_fmt;
         skid_ill_d   = dec_ill;
      end

      in_ready_d = ~skid_valid_d;
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_fmt_q    <= FMT_NONE;
         out_ill_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_fmt_q   <= FMT_NONE;
         skid_ill_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_fmt_q    <= out_fmt_d;
         out_ill_q    <= out_ill_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_fmt_q   <= skid_fmt_d;
         skid_ill_q   <= skid_ill_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_imm_q;
   assign out_fmt     = out_fmt_q;
   assign out_illegal = out_ill_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an RV32 instance (CNT_W=2) and an RV64
// instance share one stimulus stream and are checked against a queue model.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr;

   logic        rdy32, ov32, il32;
   logic [31:0] imm32;
   logic [2:0]  f32;
   logic [1:0]  cnt32;

   logic        rdy64, ov64, il64;
   logic [63:0] imm64;
   logic [2:0]  f64;
   logic [15:0] cnt64;

   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(rdy32), .in_instr(in_instr), .out_valid(ov32),
      .out_ready(out_ready), .out_imm(imm32), .out_fmt(f32),
      .out_illegal(il32), .illegal_cnt(cnt32));

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(rdy64), .in_instr(in_instr), .out_valid(ov64),
      .out_ready(out_ready), .out_imm(imm64), .out_fmt(f64),
      .out_illegal(il64), .illegal_cnt(cnt64));

   int checks = 0;
   int fails  = 0;

   // Model: accepted words in order; front entry is what out_* shows
   logic [31:0] q[$];
   int unsigned mcnt32, mcnt64;
   bit          mrdy, mknown, mfresh;

   // Immediate from field arithmetic on a 64-bit signed view of the word
   function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                   output longint imm, output int fmt,
                                   output bit ill);
      longint s;
      s   = longint'($signed(ins));
      imm = 0; fmt = 7; ill = 1'b1;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: begin imm = s >>> 20; fmt = 0; ill = 1'b0; end
         7'h1B: if (x64) begin imm = s >>> 20; fmt = 0; ill = 1'b0; end
         7'h23: begin
            imm = (s >>> 25) * 32 + longint'(ins[11:7]);
            fmt = 1; ill = 1'b0;
         end
         7'h63: begin
            imm = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            fmt = 2; ill = 1'b0;
         end
         7'h37, 7'h17: begin imm = (s >>> 12) * 4096; fmt = 3; ill = 1'b0; end
         7'h6F: begin
            imm = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            fmt = 4; ill = 1'b0;
         end
         7'h33: begin imm = 0; fmt = 7; ill = 1'b0; end
         default: begin imm = 0; fmt = 7; ill = 1'b1; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      longint imm;
      int     fmt;
      bit     ill;
      logic [31:0] e32;
      if (!mknown) return;
      chk("in_ready32", 64'(rdy32), 64'(mrdy && q.size() < 2));
      chk("in_ready64", 64'(rdy64), 64'(mrdy && q.size() < 2));
      chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
      chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
      if (q.size() > 0) begin
         ref_dec(q[0], 1'b0, imm, fmt, ill);
         e32 = imm[31:0];
         chk("imm32", 64'(imm32), 64'(e32));
         chk("fmt32", 64'(f32), 64'(fmt));
         chk("ill32", 64'(il32), 64'(ill));
         ref_dec(q[0], 1'b1, imm, fmt, ill);
         chk("imm64", imm64, 64'(imm));
         chk("fmt64", 64'(f64), 64'(fmt));
         chk("ill64", 64'(il64), 64'(ill));
      end else if (mfresh) begin
         chk("rst_imm32", 64'(imm32), 64'd0);
         chk("rst_fmt32", 64'(f32), 64'd7);
         chk("rst_ill32", 64'(il32), 64'd0);
         chk("rst_imm64", imm64, 64'd0);
         chk("rst_fmt64", 64'(f64), 64'd7);
      end
      chk("cnt32", 64'(cnt32), 64'(mcnt32));
      chk("cnt64", 64'(cnt64), 64'(mcnt64));
   endtask

   // Check current outputs, then advance one clock and update the model
   task automatic cycle();
      bit acc, ohs, ill32m, ill64m;
      longint imm;
      int fmt;
      logic [31:0] w;
      check_all();
      w   = in_instr;
      acc = mknown && rst_n && !flush && in_valid && mrdy && (q.size() < 2);
      ohs = mknown && (q.size() > 0) && out_ready;
      ill32m = 1'b0; ill64m = 1'b0;
      if (ohs) begin
         ref_dec(q[0], 1'b0, imm, fmt, ill32m);
         ref_dec(q[0], 1'b1, imm, fmt, ill64m);
      end
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         mcnt32 = 0; mcnt64 = 0;
         mrdy = 1'b0; mknown = 1'b1; mfresh = 1'b1;
      end else if (mknown) begin
         if (ohs && ill32m && mcnt32 < 3) mcnt32++;
         if (ohs && ill64m && mcnt64 < 65535) mcnt64++;
         if (flush) q.delete();
         else begin
            if (ohs) void'(q.pop_front());
            if (acc) begin q.push_back(w); mfresh = 1'b0; end
         end
         mrdy = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opcs[13];
      logic [31:0] r;
      opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
               7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};
      r = $urandom;
      return {r[31:7], opcs[$urandom_range(0, 12)]};
   endfunction

   logic [31:0] w37[5];
   logic [31:0] e37[5];
   logic [2:0]  f37[5];
   logic [31:0] w40[6];
   int accepted;

   initial begin
      w37 = '{32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h123452B7, 32'h0010006F};
      e37 = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
      f37 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      w40 = '{32'h0000007F, 32'h0000007F, 32'h00000033,
              32'h0000007F, 32'h0000007F, 32'h0000007F};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0;
      mknown = 1'b0; mrdy = 1'b0; mfresh = 1'b1; mcnt32 = 0; mcnt64 = 0;
      @(negedge clk);

      // Reset, including input offered during reset
      cycle();
      in_valid = 1'b1; in_instr = 32'h00000013;
      cycle();
      chk("rst_in_ready", 64'(rdy32), 64'd0);
      chk("rst_out_valid", 64'(ov32), 64'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      cycle();
      chk("ready_after_rst", 64'(rdy32), 64'd1);

      // Directed stream, full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_instr = w37[i];
         cycle();
         chk("stream_imm", 64'(imm32), 64'(e37[i]));
         chk("stream_fmt", 64'(f32), 64'(f37[i]));
         chk("stream_valid", 64'(ov32), 64'd1);
      end
      in_valid = 1'b0;
      cycle();

      // RV64 sign extension of a U immediate
      in_valid = 1'b1; in_instr = 32'h800002B7;
      cycle();
      in_valid = 1'b0;
      chk("u64_imm", imm64, 64'hFFFFFFFF80000000);
      chk("u64_fmt", 64'(f64), 64'd3);
      chk("u32_imm", 64'(imm32), 64'h80000000);
      cycle();

      // Stall for 3 cycles with input offered every cycle
      out_ready = 1'b0; accepted = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instr = w37[i];
         if (rdy32) accepted++;
         cycle();
      end
      chk("stall_accepts", 64'(accepted), 64'd2);
      chk("stall_ready", 64'(rdy32), 64'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("drain_first", 64'(imm32), 64'(e37[0]));
      cycle();
      chk("drain_second_valid", 64'(ov32), 64'd1);
      chk("drain_second", 64'(imm32), 64'(e37[1]));
      chk("drain_ready", 64'(rdy32), 64'd1);
      cycle();
      chk("drain_empty", 64'(ov32), 64'd0);

      // Illegal counting with saturation on the 2-bit counter
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_instr = w40[i];
         cycle();
         if (i == 2) chk("rtype_not_illegal", 64'(il32), 64'd0);
         else        chk("illegal_flag", 64'(il32), 64'd1);
      end
      in_valid = 1'b0;
      cycle();
      chk("cnt_saturated", 64'(cnt32), 64'd3);
      chk("cnt64_five", 64'(cnt64), 64'd5);

      // Flush with both entries full and no output handshake
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
      cycle();
      in_instr = 32'h00000013;
      cycle();
      chk("full_ready", 64'(rdy32), 64'd0);
      flush = 1'b1; in_instr = 32'h00000037;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 64'(ov32), 64'd0);
      chk("flush_ready", 64'(rdy32), 64'd1);
      chk("flush_cnt64", 64'(cnt64), 64'd5);
      cycle();

      // Flush coinciding with delivery of an illegal result still counts
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
      cycle();
      in_valid = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_hs_cnt64", 64'(cnt64), 64'd6);

      // Randomized traffic with occasional flush and reset
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 3) != 0);
         in_instr  = rand_instr();
         cycle();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();

      // Mid-stream reset discards in-flight results
      in_valid = 1'b1; in_instr = 32'h0000007F;
      cycle();
      out_ready = 1'b0; in_instr = 32'h00000013;
      cycle();
      in_instr = 32'h0000006F;
      cycle();
      rst_n = 1'b0; out_ready = 1'b1;
      cycle();
      rst_n = 1'b1; in_valid = 1'b0;
      chk("midrst_valid", 64'(ov32), 64'd0);
      chk("midrst_cnt", 64'(cnt32), 64'd0);
      chk("midrst_cnt64", 64'(cnt64), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("midrst_no_stale", 64'(ov32), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
